// File: rtl/udp_pkg.sv
// Shared constants and types for the video-to-UDP transmit packetizer.
// Pure definitions: no logic, no latency.
// Not applicable: no flow control lives here.
package udp_pkg;

    localparam logic [31:0] FRAME_HEAD_DEF = 32'hF3ED7A93;
    localparam logic [15:0] HDR_LEN_BASE   = 16'd4;
    localparam logic [15:0] HDR_LEN_SEQ    = 16'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_HEAD = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_t;

    // Frame header as it goes on the wire, sync word first.
    typedef struct packed {
        logic [31:0] sync;
        logic [15:0] seq;
    } frame_hdr_t;

    function automatic logic [15:0] pkt_bytes_f(input logic [24:0] left, input logic [15:0] max_len);
        return (left > {9'b0, max_len}) ? max_len : left[15:0];
    endfunction

endpackage

// File: rtl/udp_tx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a written word is visible on o_rd_dat the cycle after the write.
// Backpressure: writes while full and reads while empty are dropped.
module udp_tx_fifo #(
    parameter int DEPTH = 1024,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_vld,
    input  logic [W-1:0]             i_wr_dat,
    input  logic                     i_rd_rdy,
    output logic [W-1:0]             o_rd_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_wr;
    logic         w_rd;

    assign o_count  = r_wp - r_rp;
    assign o_full   = (o_count == FULL_CNT);
    assign o_empty  = (r_wp == r_rp);
    assign w_wr     = i_wr_vld & ~o_full;
    assign w_rd     = i_rd_rdy & ~o_empty;
    assign o_rd_dat = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp[AW-1:0]] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + (AW+1)'(1);
            end
            if (w_rd) begin
                r_rp <= r_rp + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/udp_tx_pkt.sv
// Video-to-UDP packetizer: pixel FIFO feeding request/ack-framed byte packets; UDP_TX_FRAME_SEQ_EN adds a frame sequence field.
// Latency: first header byte one cycle after app_tx_ack; payload then streams at one byte per cycle with no bubbles.
// Backpressure: pix_ready drops when the pixel FIFO is full; a packet is only requested once all its words are buffered.
module udp_tx_pkt
    import udp_pkg::*;
#(
    parameter logic [31:0] FRAME_HEAD  = FRAME_HEAD_DEF,
    parameter logic [24:0] FRAME_BYTES = 25'd1843200,
    parameter logic [15:0] PKT_LEN     = 16'd1024,
    parameter int          FIFO_DEPTH  = 1024,
    parameter int          IFG_CYCLES  = 8
) (
    input  logic        app_tx_clk,
    input  logic        rstn,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        app_tx_data_request,
    input  logic        app_tx_ack,
    output logic        app_tx_data_valid,
    output logic [7:0]  app_tx_data,
    output logic [15:0] app_tx_data_length,
    output logic        frame_done,
    output logic        sync_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [23:0] PIX_LAST = FRAME_BYTES[24:1] - 24'd1;
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
`ifdef UDP_TX_FRAME_SEQ_EN
    localparam logic [15:0] HDR_LEN  = HDR_LEN_SEQ;
`else
    localparam logic [15:0] HDR_LEN  = HDR_LEN_BASE;
`endif
    localparam logic [2:0]  HIDX_LAST = 3'(HDR_LEN - 16'd1);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic        r_run;
    logic        r_sync_err;
    logic [23:0] r_in_cnt;
    logic [24:0] r_left;
    logic [15:0] r_pkt_bytes;
    logic [15:0] r_len;
    logic        r_first;
    logic [2:0]  r_hidx;
    logic [15:0] r_bcnt;
    logic [15:0] r_gap;
    logic [15:0] r_seq;

    logic          w_full;
    logic          w_empty;
    logic [15:0]   w_rd_dat;
    logic [CW-1:0] w_count;
    logic          w_accept;
    logic          w_store;
    logic          w_pop;
    logic          w_first;
    logic [15:0]   w_pkt_bytes;
    logic          w_start;
    logic          w_last_byte;
    logic          w_frame_end;
    frame_hdr_t    w_hdr;
    logic [47:0]   w_hdr_sh;

    // Input side: hunt for sof at count 0, afterwards the pixel count alone delimits frames.
    assign pix_ready = r_run & ~w_full;
    assign w_accept  = pix_valid & pix_ready;
    assign w_store   = w_accept & (pix_sof | (r_in_cnt != 24'd0));
    assign sync_err  = r_sync_err;

    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            r_run      <= 1'b0;
            r_sync_err <= 1'b0;
            r_in_cnt   <= '0;
        end else begin
            r_run      <= 1'b1;
            r_sync_err <= w_accept & pix_sof & (r_in_cnt != 24'd0);
            if (w_store) begin
                r_in_cnt <= (r_in_cnt == PIX_LAST) ? 24'd0 : r_in_cnt + 24'd1;
            end
        end
    end

    udp_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk      (app_tx_clk),
        .rst_n    (rstn),
        .i_wr_vld (w_store),
        .i_wr_dat (pix_data),
        .i_rd_rdy (w_pop),
        .o_rd_dat (w_rd_dat),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    assign w_first     = (r_left == FRAME_BYTES);
    assign w_pkt_bytes = pkt_bytes_f(r_left, PKT_LEN);
    assign w_start     = ({{(25-CW){1'b0}}, w_count} >= {10'b0, w_pkt_bytes[15:1]});
    assign w_last_byte = (r_bcnt == r_pkt_bytes - 16'd1);
    assign w_frame_end = (r_left == {9'b0, r_pkt_bytes});
    assign w_pop       = (r_state == ST_DATA) & r_bcnt[0] & ~w_empty;
    assign frame_done  = (r_state == ST_DATA) & w_last_byte & w_frame_end;
    assign app_tx_data_length = r_len;

    assign w_hdr.sync = FRAME_HEAD;
    assign w_hdr.seq  = r_seq;
    assign w_hdr_sh   = w_hdr << {r_hidx, 3'b000};

    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        app_tx_data_request = 1'b0;
        app_tx_data_valid   = 1'b0;
        app_tx_data         = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                app_tx_data_request = 1'b1;
                if (app_tx_ack) begin
                    w_state_nxt = r_first ? ST_HEAD : ST_DATA;
                end
            end
            ST_HEAD: begin
                app_tx_data_valid = 1'b1;
                app_tx_data       = w_hdr_sh[47:40];
                if (r_hidx == HIDX_LAST) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                app_tx_data_valid = 1'b1;
                app_tx_data       = r_bcnt[0] ? w_rd_dat[7:0] : w_rd_dat[15:8];
                if (w_last_byte) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == IFG_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Packet length is latched on leaving IDLE so it stays put through REQ, HEAD and DATA.
    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            r_left      <= FRAME_BYTES;
            r_pkt_bytes <= '0;
            r_len       <= '0;
            r_first     <= 1'b0;
            r_hidx      <= '0;
            r_bcnt      <= '0;
            r_gap       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_pkt_bytes <= w_pkt_bytes;
                        r_first     <= w_first;
                        r_len       <= w_first ? w_pkt_bytes + HDR_LEN : w_pkt_bytes;
                    end
                end
                ST_REQ: begin
                    r_hidx <= '0;
                    r_bcnt <= '0;
                end
                ST_HEAD: r_hidx <= r_hidx + 3'd1;
                ST_DATA: begin
                    r_bcnt <= r_bcnt + 16'd1;
                    if (w_last_byte) begin
                        r_gap  <= '0;
                        r_left <= w_frame_end ? FRAME_BYTES : r_left - {9'b0, r_pkt_bytes};
                    end
                end
                ST_GAP: r_gap <= r_gap + 16'd1;
                default: ;
            endcase
        end
    end

`ifdef UDP_TX_FRAME_SEQ_EN
    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            r_seq <= '0;
        end else if (frame_done) begin
            r_seq <= r_seq + 16'd1;
        end
    end
`else
    assign r_seq = 16'h0000;
`endif

endmodule
